// File: rtl/fir_sample_driver.sv
// Host-side driver for the FIR_FILTER core: buffers upstream samples, paces
// one-cycle WR strobes, captures oDATA a fixed latency later and streams it out.
module fir_sample_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIR_LAT    = 1,
  parameter int WR_PERIOD  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] iSAMPLE,
  input  logic        iSAMPLE_VALID,
  output logic        oSAMPLE_READY,
  output logic        oFIR_WR,
  output logic [15:0] oFIR_DATA,
  input  logic [38:0] iFIR_DATA,
  output logic [38:0] oRESULT,
  output logic        oRESULT_VALID,
  input  logic        iRESULT_READY,
  output logic [15:0] oRESULT_CNT,
  output logic        oBUSY
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int PW = $clog2(WR_PERIOD + 1);
  localparam int LW = (FIR_LAT > 1) ? $clog2(FIR_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_e;

  state_e                       state_q, state_d;
  logic [FIFO_DEPTH-1:0][15:0]  mem_q, mem_d;
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [PW-1:0]                per_q, per_d;
  logic [LW-1:0]                wait_q, wait_d;
  logic                         fir_wr_q, fir_wr_d;
  logic [15:0]                  fir_data_q, fir_data_d;
  logic [38:0]                  result_q, result_d;
  logic                         result_vld_q, result_vld_d;
  logic [15:0]                  result_cnt_q, result_cnt_d;

  logic full, empty, push, pop, issue;

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = iSAMPLE_VALID && !full;
  // A held result blocks issue unless it is being taken on this same edge.
  assign issue = (state_q == IDLE) && !empty && (per_q == '0) &&
                 (!result_vld_q || iRESULT_READY);
  assign pop   = issue;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = iSAMPLE;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    fir_wr_d     = 1'b0;
    fir_data_d   = fir_data_q;
    wait_d       = wait_q;
    result_d     = result_q;
    result_vld_d = result_vld_q;
    result_cnt_d = result_cnt_q;
    per_d        = (per_q != '0) ? per_q - PW'(1) : per_q;
    if (result_vld_q && iRESULT_READY) result_vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          fir_wr_d   = 1'b1;
          fir_data_d = mem_q[rd_ptr_q];
          per_d      = PW'(WR_PERIOD - 1);
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        wait_d  = LW'(FIR_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == '0) begin
          result_d     = iFIR_DATA;
          result_vld_d = 1'b1;
          result_cnt_d = result_cnt_q + 16'd1;
          state_d      = CAPTURE;
        end else begin
          wait_d = wait_q - LW'(1);
        end
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      mem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      per_q        <= '0;
      wait_q       <= '0;
      fir_wr_q     <= 1'b0;
      fir_data_q   <= '0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
      result_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      per_q        <= per_d;
      wait_q       <= wait_d;
      fir_wr_q     <= fir_wr_d;
      fir_data_q   <= fir_data_d;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
      result_cnt_q <= result_cnt_d;
    end
  end

  assign oSAMPLE_READY = !full;
  assign oFIR_WR       = fir_wr_q;
  assign oFIR_DATA     = fir_data_q;
  assign oRESULT       = result_q;
  assign oRESULT_VALID = result_vld_q;
  assign oRESULT_CNT   = result_cnt_q;
  assign oBUSY         = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_fir_sample_driver.sv
// Bench for fir_sample_driver: instance A (defaults) against a cycle-rule model,
// instance B (FIR_LAT=3, WR_PERIOD=5) with directed latency checks and a scoreboard.
module tb_fir_sample_driver;
  localparam int LAT_A = 1, PER_A = 4, DEP = 4, LAT_B = 3, PER_B = 5;

  logic clk = 1'b0, rst_n = 1'b1;
  int   cyc = 0, checks = 0, errors = 0;
  bit   fir_mode = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] a_s = '0, a_wdat, a_cnt;
  logic        a_sv = 1'b0, a_rr = 1'b0, a_rdy, a_wr, a_vld, a_busy;
  logic [38:0] a_fir = '0, a_res;
  logic [15:0] b_s = '0, b_wdat, b_cnt;
  logic        b_sv = 1'b0, b_rr = 1'b0, b_rdy, b_wr, b_vld, b_busy;
  logic [38:0] b_fir = '0, b_res;

  fir_sample_driver dut_a (
    .CLK(clk), .RESET(rst_n), .iSAMPLE(a_s), .iSAMPLE_VALID(a_sv), .oSAMPLE_READY(a_rdy),
    .oFIR_WR(a_wr), .oFIR_DATA(a_wdat), .iFIR_DATA(a_fir), .oRESULT(a_res),
    .oRESULT_VALID(a_vld), .iRESULT_READY(a_rr), .oRESULT_CNT(a_cnt), .oBUSY(a_busy));

  fir_sample_driver #(.FIFO_DEPTH(DEP), .FIR_LAT(LAT_B), .WR_PERIOD(PER_B)) dut_b (
    .CLK(clk), .RESET(rst_n), .iSAMPLE(b_s), .iSAMPLE_VALID(b_sv), .oSAMPLE_READY(b_rdy),
    .oFIR_WR(b_wr), .oFIR_DATA(b_wdat), .iFIR_DATA(b_fir), .oRESULT(b_res),
    .oRESULT_VALID(b_vld), .iRESULT_READY(b_rr), .oRESULT_CNT(b_cnt), .oBUSY(b_busy));

  function automatic logic [38:0] fA(input logic [15:0] d);
    return fir_mode ? {d, 7'h2B, d} : {23'h0, d};
  endfunction
  function automatic logic [38:0] fB(input logic [15:0] d);
    return {7'h11, d, d};
  endfunction

  // FIR stand-ins: A answers one edge after WR, B three edges after WR.
  logic [1:0]  b_pv = '0;
  logic [15:0] b_pd0 = '0, b_pd1 = '0;
  always @(posedge clk) if (a_wr) a_fir <= fA(a_wdat);
  always @(posedge clk) begin
    b_pv  <= {b_pv[0], b_wr};
    b_pd0 <= b_wdat;
    b_pd1 <= b_pd0;
    if (b_pv[1]) b_fir <= fB(b_pd1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Model of A: pending samples, issued samples awaiting capture, held result.
  logic [15:0] mq[$];
  logic [38:0] pq[$], res_log[$];
  int          wr_log[$];
  logic [38:0] exp_res = '0;
  bit          exp_vld = 1'b0, exp_wr = 1'b0;
  logic [15:0] mdl_cnt = '0, last_dat = '0;
  int          wr_cyc = -1000;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_wr",   64'(a_wr),   64'd0);
      chk("rst_wdat", 64'(a_wdat), 64'd0);
      chk("rst_res",  64'(a_res),  64'd0);
      chk("rst_vld",  64'(a_vld),  64'd0);
      chk("rst_cnt",  64'(a_cnt),  64'd0);
      chk("rst_busy", 64'(a_busy), 64'd0);
      chk("rst_rdy",  64'(a_rdy),  64'd1);
      mq.delete(); pq.delete();
      exp_vld = 1'b0; exp_wr = 1'b0; mdl_cnt = '0; last_dat = '0; wr_cyc = -1000;
    end else begin
      chk("wr", 64'(a_wr), 64'(exp_wr));
      if (a_wr) begin
        wr_cyc = cyc;
        wr_log.push_back(cyc);
        chk("wr_has_sample", 64'(mq.size() > 0), 64'd1);
        if (mq.size() > 0) begin
          last_dat = mq.pop_front();
          pq.push_back(fA(last_dat));
        end
      end
      chk("wdat", 64'(a_wdat), 64'(last_dat));
      if (cyc == wr_cyc + LAT_A + 1 && pq.size() > 0) begin
        exp_res = pq.pop_front();
        exp_vld = 1'b1;
        mdl_cnt++;
      end
      chk("vld", 64'(a_vld), 64'(exp_vld));
      if (exp_vld) chk("res", 64'(a_res), 64'(exp_res));
      chk("cnt",  64'(a_cnt),  64'(mdl_cnt));
      chk("rdy",  64'(a_rdy),  64'(mq.size() < DEP));
      chk("busy", 64'(a_busy), 64'(mq.size() > 0 || cyc - wr_cyc <= LAT_A + 1));
      // Next-edge issue: sample already buffered, period elapsed, FSM back in IDLE, result slot free.
      exp_wr = mq.size() > 0 && cyc - wr_cyc >= PER_A - 1 && cyc - wr_cyc >= LAT_A + 2 &&
               (!exp_vld || a_rr);
      if (exp_vld && a_rr) begin
        res_log.push_back(exp_res);
        exp_vld = 1'b0;
      end
      if (a_sv && a_rdy) mq.push_back(a_s);
    end
  end

  logic [38:0] sentB[$], rcvdB[$];
  int          lastwr_b = -1;
  always @(negedge clk) begin
    if (!rst_n) begin
      sentB.delete(); rcvdB.delete(); lastwr_b = -1;
    end else begin
      if (b_wr) begin
        if (lastwr_b >= 0) chk("b_wr_gap", 64'(cyc - lastwr_b >= PER_B), 64'd1);
        lastwr_b = cyc;
      end
      if (b_sv && b_rdy) sentB.push_back(fB(b_s));
      if (b_vld && b_rr) rcvdB.push_back(b_res);
    end
  end

  task automatic do_reset();
    step(); rst_n = 1'b0;
    step(); step(); rst_n = 1'b1;
    wr_log.delete(); res_log.delete();
  endtask

  task automatic send(input logic [15:0] v);
    bit ok = 1'b0;
    a_sv = 1'b1; a_s = v;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); ok = a_rdy;
      step();
    end
    chk("send_accepted", 64'(ok), 64'd1);
  endtask

  initial begin
    bit found;
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // single sample
    a_rr = 1'b1; step();
    a_sv = 1'b1; a_s = 16'h1234; step(); a_sv = 1'b0;
    @(negedge clk) chk("t1_no_early_wr", 64'(a_wr), 64'd0);
    step(); @(negedge clk);
    chk("t1_wr", 64'(a_wr), 64'd1);
    chk("t1_wdat", 64'(a_wdat), 64'h1234);
    step(); @(negedge clk);
    chk("t1_wr_drop", 64'(a_wr), 64'd0);
    chk("t1_vld_early", 64'(a_vld), 64'd0);
    step(); @(negedge clk);
    chk("t1_vld", 64'(a_vld), 64'd1);
    chk("t1_res", 64'(a_res), 64'h1234);
    chk("t1_cnt", 64'(a_cnt), 64'd1);

    // burst of four
    do_reset(); a_rr = 1'b1; step();
    for (int v = 1; v <= 4; v++) begin a_sv = 1'b1; a_s = 16'(v); step(); end
    a_sv = 1'b0;
    repeat (30) step();
    chk("burst_wr_n", 64'(wr_log.size()), 64'd4);
    for (int i = 1; i < wr_log.size(); i++) chk("burst_gap", 64'(wr_log[i] - wr_log[i-1]), 64'd4);
    chk("burst_res_n", 64'(res_log.size()), 64'd4);
    for (int i = 0; i < res_log.size(); i++) chk("burst_res", 64'(res_log[i]), 64'(i + 1));
    @(negedge clk) chk("burst_cnt", 64'(a_cnt), 64'd4);

    // backpressure
    do_reset(); a_rr = 1'b0; step();
    for (int v = 1; v <= 5; v++) send(16'h0100 + 16'(v));
    a_s = 16'h0106;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rdy_low", 64'(a_rdy), 64'd0);
      step();
    end
    chk("bp_one_wr", 64'(wr_log.size()), 64'd1);
    @(negedge clk);
    chk("bp_held_vld", 64'(a_vld), 64'd1);
    chk("bp_held_res", 64'(a_res), 64'h0101);
    step(); a_rr = 1'b1;
    send(16'h0106); a_sv = 1'b0;
    repeat (40) step();
    chk("bp_res_n", 64'(res_log.size()), 64'd6);
    for (int i = 0; i < res_log.size(); i++) chk("bp_res", 64'(res_log[i]), 64'h0101 + 64'(i));

    // reset while waiting for the filter
    do_reset(); a_rr = 1'b1; step();
    send(16'hAAAA); a_sv = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); found = a_wr;
      if (!found) step();
    end
    chk("rst_t_wr_seen", 64'(found), 64'd1);
    chk("rst_t_wdat", 64'(a_wdat), 64'hAAAA);
    step(); rst_n = 1'b0; #1;
    chk("rst_t_wdat0", 64'(a_wdat), 64'd0);
    chk("rst_t_busy0", 64'(a_busy), 64'd0);
    chk("rst_t_rdy1", 64'(a_rdy), 64'd1);
    step(); step(); rst_n = 1'b1;
    wr_log.delete(); res_log.delete();
    repeat (10) step();
    chk("rst_t_no_result", 64'(res_log.size()), 64'd0);
    chk("rst_t_no_vld", 64'(a_vld), 64'd0);

    // count wrap
    do_reset(); a_rr = 1'b1; fir_mode = 1'b1; step();
    force dut_a.result_cnt_q = 16'hFFFF;
    mdl_cnt = 16'hFFFF;
    step(); step();
    release dut_a.result_cnt_q;
    @(negedge clk) chk("wrap_pre", 64'(a_cnt), 64'hFFFF);
    step();
    send(16'h0F0F); a_sv = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); found = a_vld;
      if (!found) step();
    end
    chk("wrap_vld", 64'(found), 64'd1);
    chk("wrap_cnt", 64'(a_cnt), 64'd0);
    chk("wrap_res", 64'(a_res), 64'({16'h0F0F, 7'h2B, 16'h0F0F}));

    // randomized traffic on A
    do_reset(); step();
    for (int i = 0; i < 700; i++) begin
      a_sv = ($urandom_range(0, 9) < 6);
      a_s  = 16'($urandom);
      a_rr = ($urandom_range(0, 9) < 7);
      step();
    end
    a_sv = 1'b0; a_rr = 1'b1;
    repeat (40) step();

    // B: longer filter latency
    do_reset(); b_rr = 1'b1; step();
    b_sv = 1'b1; b_s = 16'h8001; step(); b_sv = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); found = b_wr;
      if (!found) step();
    end
    chk("b_wr_seen", 64'(found), 64'd1);
    chk("b_wdat", 64'(b_wdat), 64'h8001);
    for (int k = 1; k <= 4; k++) begin
      step(); @(negedge clk);
      chk("b_vld_lat", 64'(b_vld), 64'(k == 4));
    end
    chk("b_res", 64'(b_res), 64'({7'h11, 16'h8001, 16'h8001}));
    chk("b_cnt1", 64'(b_cnt), 64'd1);
    repeat (3) step();
    @(negedge clk) chk("b_wdat_hold", 64'(b_wdat), 64'h8001);
    step();
    for (int i = 0; i < 300; i++) begin
      b_sv = ($urandom_range(0, 1) == 1);
      b_s  = 16'($urandom);
      b_rr = ($urandom_range(0, 4) < 3);
      step();
    end
    b_sv = 1'b0; b_rr = 1'b1;
    repeat (60) step();
    chk("b_res_n", 64'(rcvdB.size()), 64'(sentB.size()));
    for (int i = 0; i < sentB.size() && i < rcvdB.size(); i++)
      chk("b_res_order", 64'(rcvdB[i]), 64'(sentB[i]));
    @(negedge clk) chk("b_cnt", 64'(b_cnt), 64'(sentB.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
